// File: rtl/vx_wb_release_tracker.sv
// Per-slice writeback reassembly and register-release token FIFO.
// Optional perf counters: define VX_WB_RELEASE_PERF_EN.
module vx_wb_release_tracker #(
    parameter int NUM_WIS       = 4,
    parameter int RDW           = 6,
    parameter int SIMD_WIDTH    = 4,
    parameter int MAX_BEATS     = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int PERF_CTR_BITS = 44,
    localparam int WISW  = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1,
    localparam int BEATW = $clog2(MAX_BEATS + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb_valid,
    input  logic [WISW-1:0]          wb_wis,
    input  logic [RDW-1:0]           wb_rd,
    input  logic [SIMD_WIDTH-1:0]    wb_tmask,
    input  logic                     wb_sop,
    input  logic                     wb_eop,
    output logic                     rel_valid,
    input  logic                     rel_ready,
    output logic [WISW-1:0]          rel_wis,
    output logic [RDW-1:0]           rel_rd,
    output logic [BEATW-1:0]         rel_beats,
    output logic [NUM_WIS-1:0]       busy_warps,
    output logic                     err_proto,
    output logic                     err_overflow,
    input  logic                     err_clear,
    output logic [PERF_CTR_BITS-1:0] perf_releases,
    output logic [PERF_CTR_BITS-1:0] perf_stalls
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } wstate_e;

    typedef struct packed {
        logic [WISW-1:0]  wis;
        logic [RDW-1:0]   rd;
        logic [BEATW-1:0] beats;
    } tok_t;

    wstate_e          state_q  [NUM_WIS];
    wstate_e          state_d  [NUM_WIS];
    logic [RDW-1:0]   cur_rd_q [NUM_WIS];
    logic [RDW-1:0]   cur_rd_d [NUM_WIS];
    logic [BEATW-1:0] beats_q  [NUM_WIS];
    logic [BEATW-1:0] beats_d  [NUM_WIS];

    logic             push;
    tok_t             push_tok;
    logic             proto_hit;
    logic             act;
    logic             over;
    logic [BEATW-1:0] nxt_beats;

    logic unused_tmask;
    assign unused_tmask = ^wb_tmask;

    always_comb begin
        state_d   = state_q;
        cur_rd_d  = cur_rd_q;
        beats_d   = beats_q;
        push      = 1'b0;
        push_tok  = '0;
        proto_hit = 1'b0;
        act       = state_q[wb_wis] == S_ACTIVE;
        over      = 1'b0;
        nxt_beats = '0;
        if (wb_valid) begin
            unique case (1'b1)
                (act && !wb_sop): begin
                    over      = beats_q[wb_wis] == BEATW'(MAX_BEATS);
                    nxt_beats = over ? BEATW'(MAX_BEATS)
                                     : beats_q[wb_wis] + 1'b1;
                    if (over || (wb_rd != cur_rd_q[wb_wis]))
                        proto_hit = 1'b1;
                    beats_d[wb_wis] = nxt_beats;
                    if (wb_eop) begin
                        push           = 1'b1;
                        push_tok.wis   = wb_wis;
                        push_tok.rd    = cur_rd_q[wb_wis];
                        push_tok.beats = nxt_beats;
                        state_d[wb_wis] = S_IDLE;
                    end
                end
                (!act || wb_sop): begin
                    // sop on an open instruction abandons it and restarts
                    if (act)
                        proto_hit = 1'b1;
                    state_d[wb_wis] = S_IDLE;
                    if (!wb_sop) begin
                        proto_hit = 1'b1;
                    end else if (wb_eop) begin
                        push           = 1'b1;
                        push_tok.wis   = wb_wis;
                        push_tok.rd    = wb_rd;
                        push_tok.beats = BEATW'(1);
                    end else begin
                        state_d[wb_wis]  = S_ACTIVE;
                        cur_rd_d[wb_wis] = wb_rd;
                        beats_d[wb_wis]  = BEATW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WIS; i++) begin
                state_q[i]  <= S_IDLE;
                cur_rd_q[i] <= '0;
                beats_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_rd_q <= cur_rd_d;
            beats_q  <= beats_d;
        end
    end

    always_comb begin
        busy_warps = '0;
        for (int i = 0; i < NUM_WIS; i++)
            busy_warps[i] = state_q[i] == S_ACTIVE;
    end

    tok_t        mem_q [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q;
    logic [PW:0] rd_ptr_q;
    logic        empty;
    logic        full;
    logic        pop;
    logic        do_push;
    logic        ovf_hit;
    tok_t        head;

    assign empty   = wr_ptr_q == rd_ptr_q;
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW])
                  && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop     = rel_valid && rel_ready;
    // a pop in the same cycle frees the slot, so full+push+pop is legal
    assign do_push = push && (!full || pop);
    assign ovf_hit = push && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[PW-1:0]] <= push_tok;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign head      = mem_q[rd_ptr_q[PW-1:0]];
    assign rel_valid = !empty;
    assign rel_wis   = head.wis;
    assign rel_rd    = head.rd;
    assign rel_beats = head.beats;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_proto    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_proto    <= (err_proto && !err_clear) || proto_hit;
            err_overflow <= (err_overflow && !err_clear) || ovf_hit;
        end
    end

`ifdef VX_WB_RELEASE_PERF_EN
    logic [PERF_CTR_BITS-1:0] rel_cnt_q;
    logic [PERF_CTR_BITS-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rel_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop)
                rel_cnt_q <= rel_cnt_q + 1'b1;
            if (rel_valid && !rel_ready)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign perf_releases = rel_cnt_q;
    assign perf_stalls   = stall_cnt_q;
`else
    assign perf_releases = '0;
    assign perf_stalls   = '0;
`endif

endmodule
